// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform select/distribute paths.
package dds_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned OVR_W  = 8;

  // Channel indices, identical to the forward waveform mux select encoding.
  localparam logic [SEL_W-1:0] CH_SINE   = 2'd0;
  localparam logic [SEL_W-1:0] CH_SQUARE = 2'd1;
  localparam logic [SEL_W-1:0] CH_TRI    = 2'd2;
  localparam logic [SEL_W-1:0] CH_SAW    = 2'd3;

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel slice: holding register, full flag and handshake.
// Data holds its last value after consumption; it changes only on load.
module demux_chan_reg #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         acc_o
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  // Next-state: consume clears full, a same-cycle load keeps it set.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (full_q && ready_i) full_d = 1'b0;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  // Empty, or full and being drained this cycle (pass-through refill).
  assign acc_o  = !full_q || ready_i;
  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/demux_4_stream.sv
// Steers one sample stream to four registered valid/ready channels,
// with optional all-or-nothing broadcast and a saturating overrun counter.
// in_ready depends combinationally on out_ready, never on in_valid.
module demux_4_stream
  import dds_pkg::*;
#(
  parameter int unsigned m = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [m-1:0]      in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [m-1:0]      out_data0,
  output logic [m-1:0]      out_data1,
  output logic [m-1:0]      out_data2,
  output logic [m-1:0]      out_data3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [OVR_W-1:0]  overrun_cnt
);

  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] full;
  logic [m-1:0]      chan_data [NUM_CH];
  logic [OVR_W-1:0]  ovr_q, ovr_d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_reg #(.W(m)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[k]),
      .ready_i(out_ready[k]),
      .data_i (in_data),
      .data_o (chan_data[k]),
      .full_o (full[k]),
      .acc_o  (acc[k])
    );
  end

  // Accept decode: selected channel, or every channel when broadcasting.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) in_ready = in_bcast ? (&acc) : acc[in_sel];
  end

  // Load-enable fan-out to the selected channel(s) on a transfer.
  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      load[k] = in_valid && in_ready && (in_bcast || (in_sel == SEL_W'(k)));
    end
  end

  // Overrun counter next-state, saturating at all-ones.
  always_comb begin
    ovr_d = ovr_q;
    if (in_valid && !in_ready && (ovr_q != '1)) ovr_d = ovr_q + OVR_W'(1);
  end

  // Overrun counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ovr_q <= '0;
    else        ovr_q <= ovr_d;
  end

  assign out_data0   = chan_data[0];
  assign out_data1   = chan_data[1];
  assign out_data2   = chan_data[2];
  assign out_data3   = chan_data[3];
  assign out_valid   = full;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_demux_4_stream.sv
// Scoreboard bench for demux_4_stream: the driver pushes expected samples
// per channel on accepted transfers, a monitor pops on every consume.
module tb_demux_4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  overrun_cnt;

  logic [11:0] od [4];
  logic [11:0] exp_q [4][$];
  int          tests = 0;
  int          fails = 0;

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  always #5 clk = ~clk;

  demux_4_stream #(.m(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_bcast   (in_bcast),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; in_ready is checked before the edge and the
  // expected samples are queued when the transfer is expected to happen.
  task automatic step(input logic [11:0] d, input logic [1:0] s, input logic b,
                      input logic v, input logic [3:0] ordy, input logic exp_rdy);
    in_data   = d;
    in_sel    = s;
    in_bcast  = b;
    in_valid  = v;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    if (v && exp_rdy) begin
      for (int k = 0; k < 4; k++)
        if (b || (int'(s) == k)) exp_q[k].push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [3:0] v,
                          input logic [11:0] d0, input logic [11:0] d1,
                          input logic [11:0] d2, input logic [11:0] d3);
    chk({name, "_valid"}, int'(out_valid), int'(v));
    chk({name, "_d0"}, int'(out_data0), int'(d0));
    chk({name, "_d1"}, int'(out_data1), int'(d1));
    chk({name, "_d2"}, int'(out_data2), int'(d2));
    chk({name, "_d3"}, int'(out_data3), int'(d3));
  endtask

  // Monitor: every consume must present the oldest expected sample.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int k = 0; k < 4; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            tests++;
            if (exp_q[k].size() == 0) begin
              fails++;
              $display("FAIL unexpected_ch%0d: got 0x%0h expected no sample", k, od[k]);
            end else begin
              logic [11:0] e;
              e = exp_q[k].pop_front();
              if (od[k] !== e) begin
                fails++;
                $display("FAIL sb_ch%0d: got 0x%0h expected 0x%0h", k, od[k], e);
              end
            end
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0;
    in_valid = 1'b0; out_ready = '0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_outs("rst", 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
    chk("rst_ovr", int'(overrun_cnt), 0);
    rst_n = 1'b1;

    // Single write to channel 2.
    step(12'hABC, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b1);
    chk_outs("single", 4'b0100, 12'h0, 12'h0, 12'hABC, 12'h0);
    step(12'h000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
    step(12'h000, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(12'h000, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b1);
    chk("single_drain", int'(out_valid), 0);
    chk("single_ovr", int'(overrun_cnt), 0);

    // Backpressure on channel 1.
    step(12'h111, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step(12'h222, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0);
    chk("bp_ovr", int'(overrun_cnt), 5);
    chk("bp_hold", int'(out_data1), 12'h111);
    step(12'h333, 2'd1, 1'b0, 1'b1, 4'b0010, 1'b1);
    chk("bp_refill_valid", int'(out_valid), 4'b0010);
    chk("bp_refill_data", int'(out_data1), 12'h333);
    step(12'h000, 2'd1, 1'b0, 1'b0, 4'b0010, 1'b1);

    // Broadcast blocked by channel 3, then released.
    step(12'h444, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b1);
    step(12'h7FF, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0);
    chk_outs("bc_block", 4'b1000, 12'h0, 12'h333, 12'hABC, 12'h444);
    chk("bc_ovr", int'(overrun_cnt), 6);
    step(12'h7FF, 2'd0, 1'b1, 1'b1, 4'b1000, 1'b1);
    chk_outs("bc_load", 4'b1111, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF);
    step(12'h000, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1);
    chk("bc_drain", int'(out_valid), 0);

    // Round-robin streaming, all consumers ready.
    for (int i = 1; i <= 400; i++)
      step(12'(i), 2'(i - 1), 1'b0, 1'b1, 4'b1111, 1'b1);
    step(12'h000, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1);
    chk("stream_drain", int'(out_valid), 0);
    chk("stream_d3", int'(out_data3), 400);
    chk("stream_ovr", int'(overrun_cnt), 6);

    // Saturation: 300 stalled cycles on top of 6.
    step(12'h555, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 300; i++) step(12'h666, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
    chk("sat_ovr", int'(overrun_cnt), 255);
    step(12'h777, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b1);
    step(12'h888, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b1);
    chk("pre_rst_valid", int'(out_valid), 4'b1011);

    // Reset mid-operation discards pending samples.
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd2; out_ready = '0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    chk_outs("midrst", 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
    chk("midrst_ovr", int'(overrun_cnt), 0);

    // Hold-last-value after consumption.
    step(12'h123, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
    chk("hold_valid", int'(out_valid), 4'b0001);
    step(12'h000, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b1);
    chk("hold_valid_clr", int'(out_valid), 0);
    chk("hold_data", int'(out_data0), 12'h123);
    step(12'h000, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1);
    chk("idle_ready_ignored", int'(out_valid), 0);

    for (int k = 0; k < 4; k++) chk($sformatf("sb_empty_ch%0d", k), exp_q[k].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_4_stream.md
Name: demux_4_stream

Overview:
- Inverse of the 4-input waveform select path: takes one stream of m-bit samples and steers each sample to one of four output channels.
- Each output channel is registered and has a valid/ready handshake, so downstream consumers (DAC shifter, mixer, debug tap) can stall independently.
- Sits between the DDS phase-to-amplitude stage and the per-voice output logic.
- Also supports a broadcast mode that copies one sample to all four channels.

Parameters:
- m, 12, sample width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_data  input  m  sample to distribute
- in_sel  input  2  destination channel (0..3), sampled with in_data
- in_bcast  input  1  1 = broadcast to all channels, in_sel ignored
- in_valid  input  1  in_data/in_sel/in_bcast valid this cycle
- in_ready  output  1  block accepts the input this cycle
- out_data0..out_data3  output  m each  channel data registers
- out_valid  output  4  bit k = out_data k holds an unconsumed sample
- out_ready  input  4  bit k = channel k consumer takes the sample this cycle
- overrun_cnt  output  8  saturating count of cycles with in_valid=1 and in_ready=0

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_data0..3 = 0, out_valid = 4'b0000, overrun_cnt = 0.
  - Reset takes effect mid-transfer; any pending samples are discarded.
  - in_ready is 0 during reset cycles.
- Per-channel state: one holding register plus a full flag. out_valid[k] = full[k].
- Channel k can accept (acc[k]) when full[k]=0, or when full[k]=1 and out_ready[k]=1 in the same cycle (pass-through refill).
- in_ready (combinational, no dependence on in_valid):
  - in_bcast=0: in_ready = acc[in_sel].
  - in_bcast=1: in_ready = AND of acc[0..3]. Broadcast is all-or-nothing; there are no partial writes.
- Transfer: in_valid & in_ready at a rising edge.
  - Selected channel(s) load in_data and set full=1.
  - Latency is 1 cycle: out_valid is visible the cycle after acceptance.
- Consume: out_valid[k] & out_ready[k] clears full[k] unless channel k is reloaded in the same cycle, in which case full stays 1 with the new data.
- out_ready[k] while out_valid[k]=0 is ignored.
- out_data k holds its last value after consumption. It changes only on load. This hold-last-value behaviour is required for DAC paths.
- Unselected channels are unaffected by a transfer.
- in_sel and in_bcast are only meaningful when in_valid=1; with in_valid=0 no state changes except consumes.
- overrun_cnt:
  - Increments by 1 on each rising edge with in_valid=1 and in_ready=0.
  - Saturates at 255; never wraps.
  - Cleared only by reset.
- Throughput: one sample per cycle sustained per channel when its consumer holds out_ready=1. Round-robin in_sel with all out_ready=1 gives one accept every cycle.
- No combinational path from in_valid to in_ready. The path from out_ready to in_ready is allowed and documented.

Decomposition:
- Shared package dds_pkg:
  - NUM_CH = 4, SEL_W = 2.
  - Localparams for channel indices CH_SINE=0, CH_SQUARE=1, CH_TRI=2, CH_SAW=3, matching the forward mux select encoding.
  - OVR_W = 8.
- Natural sub-module: demux_chan_reg, one channel slice (holding register, full flag, load/consume logic, acc output). It is instantiated four times.
- The top level holds in_ready decode, load-enable fan-out and overrun_cnt.

Test Plan:
- Reset then single write: in_data=12'hABC, in_sel=2, in_valid for 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=12'hABC, other outputs 0. in_ready stays 1 for sel≠2 and is 0 for sel=2.
- Backpressure: channel 1 full and out_ready[1]=0, drive in_sel=1 with in_valid for 5 cycles -> in_ready=0, out_data1 unchanged, overrun_cnt=5. Raising out_ready[1] gives in_ready=1 that cycle, and the new sample loads with out_valid[1] still 1.
- Broadcast: in_bcast=1, in_data=12'h7FF with channel 3 full and stalled -> in_ready=0, nothing loads. Releasing out_ready[3] -> all four load 12'h7FF, out_valid=4'b1111 next cycle.
- Streaming: in_sel cycles 0,1,2,3 with in_data 1..400 and all out_ready=1 -> in_ready continuously 1. Each channel receives every 4th value in order, with no loss and no duplicates (scoreboard check).
- Saturation and reset mid-operation: hold an overrun for 300 cycles -> overrun_cnt=255. Assert rst_n=0 for 1 cycle with out_valid=4'b1011 -> next cycle out_valid=0, all out_data=0, overrun_cnt=0.
- Hold-last-value: load 12'h123 on channel 0, consume with out_ready[0]=1 -> out_valid[0]=0 while out_data0 remains 12'h123.
